// File: rtl/alu_result_writer.sv
// Logs one ALU result per handshake as a 4-word record in SRAM via the memData/memAdd bus.
// Optional build macro ALU_WRITER_FLAGS_EN adds the flag/control word at record offset 2.
module alu_result_writer #(
  parameter logic [10:0] BASE_ADDR = 11'h400,
  parameter int          DEPTH     = 64,
  localparam int         IW        = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          valid,
  output logic          ready,
  input  logic [31:0]   aluData,
  input  logic [2:0]    control,
  input  logic          zeroFlag,
  input  logic          overflowFlag,
  input  logic          carryoutFlag,
  input  logic          negativeFlag,
  input  logic          clear,
  inout  wire  [15:0]   memData,
  output logic [10:0]   memAdd,
  output logic          nMemOut,
  output logic          nMemWrite,
  output logic [IW-1:0] recIndex,
  output logic          wrapped
);

`ifdef ALU_WRITER_FLAGS_EN
  typedef enum logic [2:0] {
    S_IDLE, S_LO_S, S_LO_W, S_HI_S, S_HI_W, S_FL_S, S_FL_W
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_LO_S, S_LO_W, S_HI_S, S_HI_W
  } state_t;
`endif

  localparam logic [IW-1:0] LAST_INDEX = IW'(DEPTH - 1);

  state_t        r_state;
  state_t        w_state_next;
  logic [31:0]   r_data;
  logic [10:0]   r_addr;
  logic [IW-1:0] r_index;
  logic          r_wrapped;
  logic          w_accept;
  logic          w_drive;
  logic          w_strobe;
  logic          w_step_addr;
  logic          w_rec_done;
  logic [15:0]   w_word;
  logic [10:0]   w_rec_base;

`ifdef ALU_WRITER_FLAGS_EN
  logic [2:0] r_ctrl;
  logic [3:0] r_flags;
`else
  logic w_unused_flags;
  assign w_unused_flags = ^{control, zeroFlag, overflowFlag, carryoutFlag, negativeFlag};
`endif

  // Records are 4 words apart; the address wraps within the 11-bit SRAM space.
  assign w_rec_base = BASE_ADDR + 11'({r_index, 2'b00});

  always_comb begin
    w_state_next = r_state;
    w_drive      = 1'b0;
    w_strobe     = 1'b0;
    w_step_addr  = 1'b0;
    w_rec_done   = 1'b0;
    w_word       = 16'h0000;
    w_accept     = (r_state == S_IDLE) && valid && !clear;
    ready        = (r_state == S_IDLE) && !clear;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_state_next = S_LO_S;
      end
      S_LO_S: begin
        w_drive      = 1'b1;
        w_word       = r_data[15:0];
        w_state_next = S_LO_W;
      end
      S_LO_W: begin
        w_drive      = 1'b1;
        w_strobe     = 1'b1;
        w_step_addr  = 1'b1;
        w_word       = r_data[15:0];
        w_state_next = S_HI_S;
      end
      S_HI_S: begin
        w_drive      = 1'b1;
        w_word       = r_data[31:16];
        w_state_next = S_HI_W;
      end
      S_HI_W: begin
        w_drive  = 1'b1;
        w_strobe = 1'b1;
        w_word   = r_data[31:16];
`ifdef ALU_WRITER_FLAGS_EN
        w_step_addr  = 1'b1;
        w_state_next = S_FL_S;
`else
        w_rec_done   = 1'b1;
        w_state_next = S_IDLE;
`endif
      end
`ifdef ALU_WRITER_FLAGS_EN
      S_FL_S: begin
        w_drive      = 1'b1;
        w_word       = {9'b0, r_ctrl, r_flags};
        w_state_next = S_FL_W;
      end
      S_FL_W: begin
        w_drive      = 1'b1;
        w_strobe     = 1'b1;
        w_rec_done   = 1'b1;
        w_word       = {9'b0, r_ctrl, r_flags};
        w_state_next = S_IDLE;
      end
`endif
      default: w_state_next = S_IDLE;
    endcase
    nMemWrite = !w_strobe;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_data    <= '0;
      r_addr    <= '0;
      r_index   <= '0;
      r_wrapped <= 1'b0;
`ifdef ALU_WRITER_FLAGS_EN
      r_ctrl    <= '0;
      r_flags   <= '0;
`endif
    end else begin
      r_state <= w_state_next;
      if ((r_state == S_IDLE) && clear) begin
        r_index   <= '0;
        r_wrapped <= 1'b0;
      end
      if (w_accept) begin
        r_data  <= aluData;
        r_addr  <= w_rec_base;
`ifdef ALU_WRITER_FLAGS_EN
        r_ctrl  <= control;
        r_flags <= {negativeFlag, carryoutFlag, overflowFlag, zeroFlag};
`endif
      end else if (w_step_addr) begin
        r_addr <= r_addr + 11'd1;
      end
      if (w_rec_done) begin
        if (r_index == LAST_INDEX) begin
          r_index   <= '0;
          r_wrapped <= 1'b1;
        end else begin
          r_index <= r_index + 1'b1;
        end
      end
    end
  end

  assign memData  = w_drive ? w_word : 16'bz;
  assign memAdd   = r_addr;
  assign nMemOut  = 1'b1;
  assign recIndex = r_index;
  assign wrapped  = r_wrapped;

endmodule

// File: tb/tb_alu_result_writer.sv
// Scoreboard bench for alu_result_writer: expected SRAM writes are queued at issue time
// and a negedge monitor checks every strobe; an SRAM model backs the memory checks.
module tb_alu_result_writer;
`ifdef ALU_WRITER_FLAGS_EN
  localparam int NWORDS = 3;
`else
  localparam int NWORDS = 2;
`endif
  localparam int LAT   = 2 * NWORDS;
  localparam int SPACE = LAT + 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid = 1'b0;
  logic        clear = 1'b0;
  logic [31:0] aluData = '0;
  logic [2:0]  control = '0;
  logic        zeroFlag = 1'b0, overflowFlag = 1'b0, carryoutFlag = 1'b0, negativeFlag = 1'b0;
  wire  [15:0] memData;
  logic        ready, nMemOut, nMemWrite, wrapped;
  logic [10:0] memAdd;
  logic [5:0]  recIndex;
  logic        init_mem = 1'b1;

  int n_vec = 0;
  int n_bad = 0;
  logic [15:0] sram [2048];
  logic [15:0] exp_mem [2048];
  logic [26:0] sb_q [$];
  int   exp_idx = 0;
  logic exp_wrap = 1'b0;

  logic [31:0] vd [3] = '{32'hCAFE0001, 32'h8000FFFF, 32'h00010002};
  logic [2:0]  vc [3] = '{3'b111, 3'b000, 3'b101};
  logic [3:0]  vf [3] = '{4'b1111, 4'b0001, 4'b1010};

  always #5 clk = ~clk;

  alu_result_writer #(.BASE_ADDR(11'h400), .DEPTH(64)) dut (
    .clk(clk), .rst(rst), .valid(valid), .ready(ready), .aluData(aluData),
    .control(control), .zeroFlag(zeroFlag), .overflowFlag(overflowFlag),
    .carryoutFlag(carryoutFlag), .negativeFlag(negativeFlag), .clear(clear),
    .memData(memData), .memAdd(memAdd), .nMemOut(nMemOut), .nMemWrite(nMemWrite),
    .recIndex(recIndex), .wrapped(wrapped)
  );

  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 2048; i++) sram[i] <= 16'hDEAD;
    end else if (nMemWrite === 1'b0) begin
      sram[memAdd] <= memData;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end else begin
      $display("ok   %s: %h", nm, act);
    end
  endtask

  always @(negedge clk) begin
    if (nMemWrite === 1'b0) begin
      logic [26:0] e;
      if (sb_q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_write: got addr %h data %h, required no write", memAdd, memData);
      end else begin
        e = sb_q.pop_front();
        chk("wr_addr", 32'(memAdd), 32'(e[26:16]));
        chk("wr_data", 32'(memData), 32'(e[15:0]));
        chk("wr_nMemOut", 32'(nMemOut), 32'd1);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void push_rec(input logic [10:0] base, input logic [31:0] d,
                                   input logic [2:0] c, input logic [3:0] f, input int words);
    logic [10:0] a;
    logic [15:0] w;
    for (int k = 0; k < words; k++) begin
      a = base + 11'(k);
      w = (k == 0) ? d[15:0] : (k == 1) ? d[31:16] : {9'b0, c, f};
      sb_q.push_back({a, w});
      exp_mem[a] = w;
    end
  endfunction

  function automatic void advance_idx();
    if (exp_idx == 63) begin
      exp_idx  = 0;
      exp_wrap = 1'b1;
    end else begin
      exp_idx++;
    end
  endfunction

  task automatic chk_mem(input logic [10:0] a);
    chk($sformatf("mem_%h", a), 32'(sram[a]), 32'(exp_mem[a]));
  endtask

  // One record; clr_at/rst_at pulse clear/rst in the k-th busy state (k=0 is WR_LO_S), -1 for none.
  task automatic run_rec(input logic [31:0] d, input logic [2:0] c, input logic [3:0] f,
                         input int clr_at, input int rst_at);
    int lat = 0;
    int nw = 0;
    int words;
    logic [10:0] base;
    for (int t = 0; t < 20 && !ready; t++) tick();
    base  = 11'h400 + 11'(exp_idx * 4);
    words = (rst_at < 0) ? NWORDS : (rst_at + 1) / 2;
    push_rec(base, d, c, f, words);
    valid = 1'b1;
    aluData = d;
    control = c;
    {negativeFlag, carryoutFlag, overflowFlag, zeroFlag} = f;
    tick();
    valid = 1'b0;
    aluData = ~d;
    control = ~c;
    {negativeFlag, carryoutFlag, overflowFlag, zeroFlag} = ~f;
    for (int k = 0; k < 16; k++) begin
      if (ready) break;
      lat++;
      if (nMemWrite == 1'b0) nw++;
      clear = (k == clr_at);
      rst   = (k == rst_at);
      tick();
      if (k == rst_at) begin
        rst = 1'b0;
        break;
      end
    end
    clear = 1'b0;
    if (rst_at >= 0) begin
      exp_idx  = 0;
      exp_wrap = 1'b0;
    end else begin
      chk("ready_low_cycles", 32'(lat), 32'(LAT));
      chk("strobe_cycles", 32'(nw), 32'(NWORDS));
      advance_idx();
    end
  endtask

  initial begin
    int n;
    int acc [3];
    logic [10:0] base;
    for (int i = 0; i < 2048; i++) exp_mem[i] = 16'hDEAD;

    // Reset state
    rst = 1'b1;
    repeat (3) tick();
    init_mem = 1'b0;
    rst = 1'b0;
    #1;
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_nMemWrite", 32'(nMemWrite), 32'd1);
    chk("rst_nMemOut", 32'(nMemOut), 32'd1);
    chk("rst_memAdd", 32'(memAdd), 32'd0);
    chk("rst_recIndex", 32'(recIndex), 32'd0);
    chk("rst_wrapped", 32'(wrapped), 32'd0);

    // Single record
    run_rec(32'h1234ABCD, 3'b010, 4'b0100, -1, -1);
    chk("s1_recIndex", 32'(recIndex), 32'd1);
    chk("s1_mem400", 32'(sram[11'h400]), 32'h0000ABCD);
    chk("s1_mem401", 32'(sram[11'h401]), 32'h00001234);
`ifdef ALU_WRITER_FLAGS_EN
    chk("s1_mem402", 32'(sram[11'h402]), 32'h00000024);
`else
    chk("s1_mem402", 32'(sram[11'h402]), 32'h0000DEAD);
`endif

    // clear and valid together: clear wins, no accept
    clear = 1'b1;
    valid = 1'b1;
    aluData = 32'hFFFF0000;
    #1;
    chk("clr_valid_ready", 32'(ready), 32'd0);
    tick();
    valid = 1'b0;
    clear = 1'b0;
    chk("clr_recIndex", 32'(recIndex), 32'd0);
    chk("clr_wrapped", 32'(wrapped), 32'd0);
    tick();
    chk("clr_no_accept", 32'(ready), 32'd1);
    exp_idx = 0;

    // valid held high for three records
    n = 0;
    valid = 1'b1;
    aluData = vd[0];
    control = vc[0];
    {negativeFlag, carryoutFlag, overflowFlag, zeroFlag} = vf[0];
    for (int t = 0; t < 40 && n < 3; t++) begin
      if (ready) begin
        base = 11'h400 + 11'(exp_idx * 4);
        push_rec(base, vd[n], vc[n], vf[n], NWORDS);
        advance_idx();
        acc[n] = t;
        n++;
        tick();
        if (n < 3) begin
          aluData = vd[n];
          control = vc[n];
          {negativeFlag, carryoutFlag, overflowFlag, zeroFlag} = vf[n];
        end else begin
          valid = 1'b0;
        end
      end else begin
        tick();
      end
    end
    valid = 1'b0;
    chk("b2b_accepts", 32'(n), 32'd3);
    chk("b2b_space01", 32'(acc[1] - acc[0]), 32'(SPACE));
    chk("b2b_space12", 32'(acc[2] - acc[1]), 32'(SPACE));
    for (int t = 0; t < 20 && !ready; t++) tick();
    chk("b2b_recIndex", 32'(recIndex), 32'd3);
    chk_mem(11'h408);
    chk_mem(11'h409);

    // 64 records from index 0, then the 65th overwrites record 0
    clear = 1'b1;
    tick();
    clear = 1'b0;
    exp_idx = 0;
    exp_wrap = 1'b0;
    for (int i = 0; i < 64; i++)
      run_rec(32'hA5000000 | (32'(i) * 32'h00010001), 3'(i), 4'(i), -1, -1);
    chk("wrap_recIndex", 32'(recIndex), 32'd0);
    chk("wrap_wrapped", 32'(wrapped), 32'd1);
    chk("wrap_mem4FC", 32'(sram[11'h4FC]), 32'h0000003F);
    chk("wrap_mem4FD", 32'(sram[11'h4FD]), 32'h0000A53F);
    chk_mem(11'h4FE);
    run_rec(32'h0BADF00D, 3'b110, 4'b1001, -1, -1);
    chk("ovw_mem400", 32'(sram[11'h400]), 32'h0000F00D);
    chk("ovw_mem401", 32'(sram[11'h401]), 32'h00000BAD);
    chk_mem(11'h402);
    chk("ovw_recIndex", 32'(recIndex), 32'd1);

    // clear pulsed during WR_HI_S is ignored
    run_rec(32'h13572468, 3'b001, 4'b0010, 2, -1);
    chk("busy_clr_recIndex", 32'(recIndex), 32'd2);
    chk("busy_clr_wrapped", 32'(wrapped), 32'd1);

    // rst during WR_HI_W abandons the record
    clear = 1'b1;
    tick();
    clear = 1'b0;
    exp_idx = 0;
    run_rec(32'h55667788, 3'b011, 4'b1100, -1, 3);
    chk("mid_rst_ready", 32'(ready), 32'd1);
    chk("mid_rst_nMemWrite", 32'(nMemWrite), 32'd1);
    chk("mid_rst_recIndex", 32'(recIndex), 32'd0);
    chk("mid_rst_wrapped", 32'(wrapped), 32'd0);
    chk("mid_rst_memAdd", 32'(memAdd), 32'd0);
    chk("mid_rst_mem400", 32'(sram[11'h400]), 32'h00007788);
    chk_mem(11'h402);
    repeat (3) tick();
    chk("mid_rst_stays_idle", 32'(ready), 32'd1);

    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/alu_result_writer.md
Name: alu_result_writer

Overview:
- Downstream stage of the ALU datapath: captures one 32-bit ALU result, its 3-bit control code and its four flags per handshake.
- Writes each capture as a fixed-stride record into the 16-bit SRAM through the memory interface bus (memData/memAdd/nMemOut/nMemWrite).
- Lets lab sequences leave an ALU trace in memory that the sequencing FSM or a bench can read back later.
- Sole SRAM bus master only while busy; tri-states memData otherwise.

Parameters:
- BASE_ADDR, 11'h400, SRAM word address of record 0.
- DEPTH, 64, number of records before the write index wraps; power of two, 2..256.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- valid  input  1  upstream has a result to log.
- ready  output  1  block can accept a result this cycle.
- aluData  input  32  ALU result.
- control  input  3  ALU opcode that produced aluData.
- zeroFlag, overflowFlag, carryoutFlag, negativeFlag  input  1 each  ALU flags.
- clear  input  1  reset the record index and the wrapped flag; honoured in IDLE only.
- memData  inout  16  SRAM data; driven only in write states, otherwise high-Z.
- memAdd  output  11  SRAM word address.
- nMemOut  output  1  SRAM output enable (active low); held 1.
- nMemWrite  output  1  SRAM write strobe (active low).
- recIndex  output  log2(DEPTH)  index of the next record to write.
- wrapped  output  1  sticky; set when recIndex wraps DEPTH-1 to 0.

Behaviour:
- Reset values: state IDLE, ready=1, nMemWrite=1, nMemOut=1, memAdd=0, memData=Z, recIndex=0, wrapped=0, capture registers=0.
- ready = (state==IDLE) && !clear.
- Accept occurs when valid && ready at an edge. Capture aluData, control and flags, then go to WR_LO_S.
- Record layout at base R = BASE_ADDR + 4*recIndex (11-bit modulo):
  - R+0 = aluData[15:0]
  - R+1 = aluData[31:16]
  - R+2 = flag word: {9'b0, control[2:0], negativeFlag, carryoutFlag, overflowFlag, zeroFlag}
  - R+3 = never written
- Each word takes two cycles:
  - setup (_S): memAdd and memData driven, nMemWrite=1.
  - strobe (_W): same memAdd and memData, nMemWrite=0.
- State sequence: IDLE -> WR_LO_S -> WR_LO_W -> WR_HI_S -> WR_HI_W -> WR_FL_S -> WR_FL_W -> IDLE.
- Latency: 6 cycles from the accept edge to return to IDLE. Back-to-back throughput is one record per 7 cycles, because ready is high only in IDLE.
- On leaving WR_FL_W, recIndex increments. At DEPTH-1 it goes to 0 and wrapped is set to 1.
- clear in IDLE: recIndex=0, wrapped=0, no accept. This gives clear priority over a simultaneous valid.
- clear while busy: ignored. It must be held until IDLE to take effect.
- Captured values are stable for the whole record; upstream input changes after accept have no effect.
- rst mid-record: at the next edge go to IDLE with nMemWrite=1, memData=Z, recIndex=0. The partial record is abandoned.
- memAdd holds its last value in IDLE.

Optional Feature:
- Macro: ALU_WRITER_FLAGS_EN.
- Defined: behaviour exactly as above, with the flag word written at R+2 and 6-cycle latency.
- Undefined:
  - The WR_FL_* states are not built; WR_HI_W returns to IDLE and recIndex increments there.
  - Latency is 4 cycles.
  - R+2 is left unwritten.
  - The flag and control inputs are accepted but unused.
  - Stride stays 4.

Test Plan:
- Reset then single record: aluData=32'h1234ABCD, control=3'b010, zeroFlag=0, overflowFlag=0, carryoutFlag=1, negativeFlag=0 -> SRAM[400]=ABCD, [401]=1234, [402]=0024. recIndex=1. nMemWrite low exactly 3 cycles. ready low for 6 cycles.
- valid held high for 3 records -> accepts spaced 7 cycles apart; records at 400, 404, 408; recIndex=3.
- Write 64 records -> the 64th lands at 0x4FC. recIndex=0, wrapped=1. The 65th record overwrites 0x400.
- clear and valid asserted together in IDLE -> no accept, recIndex=0, wrapped=0. clear pulsed during WR_HI_S -> recIndex still increments.
- rst asserted during WR_HI_W -> next cycle state IDLE, nMemWrite=1, memData=Z, recIndex=0, ready=1. [400] holds the low half; [402] is unchanged.
- Build without ALU_WRITER_FLAGS_EN, same record as the first scenario -> [400]=ABCD, [401]=1234, [402] untouched. ready returns after 4 cycles.
